// File: rtl/spi_frame_ctrl.sv
// SPI master frame sequencer (CPHA=0, selectable CPOL): drives the load/shift/capture
// controls of an external shift register and generates sclk, cs_n and a retimed mosi.
module spi_frame_ctrl #(
  parameter int WIDTH     = 32,
  parameter int DIV_WIDTH = 8,
  parameter int LEN_W     = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] cfg_clk_div,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_cpol,
  input  logic                 cfg_msb_first,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 abort,
  input  logic                 sr_serial_out,
  output logic                 sr_load,
  output logic                 sr_shift,
  output logic                 sr_capture,
  output logic                 sr_left_right,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  output logic                 busy,
  output logic                 rx_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] hm1_q, hm1_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 cpol_q, cpol_d;
  logic                 msb_q, msb_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;
  logic                 ready_q, ready_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 shift_q, shift_d;
  logic                 capture_q, capture_d;

  logic [DIV_WIDTH-1:0] cfg_hm1;
  logic [LEN_W-1:0]     cfg_len_eff;
  logic [LEN_W-1:0]     bit_cnt_inc;
  logic                 accept;
  logic                 half_done;
  logic                 in_idle;

  // Half-period minus one; dividers below 2 are clamped so H is never under 3 cycles.
  assign cfg_hm1     = (cfg_clk_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_clk_div;
  assign cfg_len_eff = ((cfg_len == '0) || (cfg_len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : cfg_len;

  assign in_idle     = (state_q == ST_IDLE);
  assign accept      = in_idle & start_valid & ready_q;
  assign half_done   = (cnt_q == hm1_q);
  assign bit_cnt_inc = bit_cnt_q + LEN_W'(1);

  always_comb begin
    // NOTE: every variable gets its hold/default value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    hm1_d      = hm1_q;
    len_d      = len_q;
    bit_cnt_d  = bit_cnt_q;
    cpol_d     = cpol_q;
    msb_d      = msb_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    shift_d    = 1'b0;
    capture_d  = 1'b0;

    if (!in_idle) begin
      mosi_d = sr_serial_out;
    end

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = cfg_cpol;
        if (accept) begin
          hm1_d     = cfg_hm1;
          len_d     = cfg_len_eff;
          cpol_d    = cfg_cpol;
          msb_d     = cfg_msb_first;
          cnt_d     = '0;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          shift_d   = 1'b1;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (half_done) begin
          cnt_d     = '0;
          sclk_d    = ~cpol_q;
          capture_d = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end

      ST_SHIFT: begin
        if (half_done) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q != cpol_q) begin
            // End of a leading half: this toggle is a trailing edge, one bit done.
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_inc == len_q) begin
              state_d = ST_HOLD;
            end else begin
              shift_d = 1'b1;
            end
          end else begin
            capture_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end

      ST_HOLD: begin
        if (half_done) begin
          cs_n_d     = 1'b1;
          rx_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything once a frame is in flight; in IDLE it is ignored.
    if (abort && !in_idle) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      cs_n_d     = 1'b1;
      sclk_d     = cpol_q;
      rx_valid_d = 1'b0;
      shift_d    = 1'b0;
      capture_d  = 1'b0;
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hm1_q      <= DIV_WIDTH'(2);
      len_q      <= LEN_W'(WIDTH);
      bit_cnt_q  <= '0;
      cpol_q     <= 1'b0;
      msb_q      <= 1'b1;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b1;
      ready_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      shift_q    <= 1'b0;
      capture_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of
      // the others, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hm1_q      <= hm1_d;
      len_q      <= len_d;
      bit_cnt_q  <= bit_cnt_d;
      cpol_q     <= cpol_d;
      msb_q      <= msb_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      rx_valid_q <= rx_valid_d;
      shift_q    <= shift_d;
      capture_q  <= capture_d;
    end
  end

  assign start_ready   = ready_q;
  assign sr_load       = accept;
  assign sr_shift      = shift_q;
  assign sr_capture    = capture_q;
  assign sr_left_right = msb_q;
  assign sclk          = sclk_q;
  assign cs_n          = cs_n_q;
  assign mosi          = mosi_q;
  assign busy          = ~in_idle;
  assign rx_valid      = rx_valid_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: table-driven and random frames checked cycle by
// cycle against an arithmetic timing model, plus abort, back-to-back and reset sequences.
module tb_spi_frame_ctrl;

  localparam int WIDTH     = 32;
  localparam int DIV_WIDTH = 8;
  localparam int LEN_W     = $clog2(WIDTH + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DIV_WIDTH-1:0] cfg_clk_div;
  logic [LEN_W-1:0]     cfg_len;
  logic                 cfg_cpol;
  logic                 cfg_msb_first;
  logic                 start_valid;
  logic                 start_ready;
  logic                 abort;
  logic                 sr_serial_out;
  logic                 sr_load;
  logic                 sr_shift;
  logic                 sr_capture;
  logic                 sr_left_right;
  logic                 sclk;
  logic                 cs_n;
  logic                 mosi;
  logic                 busy;
  logic                 rx_valid;

  always #5 clk = ~clk;

  spi_frame_ctrl #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_clk_div   (cfg_clk_div),
    .cfg_len       (cfg_len),
    .cfg_cpol      (cfg_cpol),
    .cfg_msb_first (cfg_msb_first),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .abort         (abort),
    .sr_serial_out (sr_serial_out),
    .sr_load       (sr_load),
    .sr_shift      (sr_shift),
    .sr_capture    (sr_capture),
    .sr_left_right (sr_left_right),
    .sclk          (sclk),
    .cs_n          (cs_n),
    .mosi          (mosi),
    .busy          (busy),
    .rx_valid      (rx_valid)
  );

  // External shift register: parallel load, and each shift moves the next bit into an
  // output flop that drives sr_serial_out.
  logic [WIDTH-1:0] tx_data = '0;
  logic [WIDTH-1:0] sreg    = '0;
  logic             out_bit = 1'b0;

  always @(posedge clk) begin
    if (sr_load) begin
      sreg <= tx_data;
    end else if (sr_shift) begin
      if (sr_left_right) begin
        out_bit <= sreg[WIDTH-1];
        sreg    <= {sreg[WIDTH-2:0], 1'b0};
      end else begin
        out_bit <= sreg[0];
        sreg    <= {1'b0, sreg[WIDTH-1:1]};
      end
    end
  end
  assign sr_serial_out = out_bit;

  int errors = 0;
  int checks = 0;
  bit last_msb = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected {cs_n, sclk, busy, start_ready, rx_valid, sr_load, sr_shift, sr_capture,
  // sr_left_right} in cycle k of a frame, k=0 being the accept cycle.
  function automatic logic [8:0] model_out(input int k, input int n, input int h,
                                           input bit cpol, input bit msb, input bit prev_msb);
    int  l;
    int  m;
    logic busy_e, sclk_e, cap_e, shift_e;
    l      = (2 * n + 1) * h;
    m      = k - h - 1;
    busy_e = (k >= 1) && (k <= l);
    sclk_e = cpol;
    cap_e  = 1'b0;
    shift_e = (k == 1);
    if (k > h && k <= l) begin
      if (((m / h) % 2) == 0) sclk_e = ~cpol;
      if ((m % (2 * h)) == 0) cap_e = 1'b1;
      if ((m % (2 * h)) == h && (m / (2 * h)) < n - 1) shift_e = 1'b1;
    end
    return {~busy_e, sclk_e, busy_e, (k == 0) || (k > l), (k == l + 1), (k == 0),
            shift_e, cap_e, (k == 0) ? prev_msb : msb};
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (start_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_start_ready: got timeout, expected start_ready within 2000 cycles");
    end
  endtask

  // Runs one frame, compares every cycle to the model and each captured mosi bit to the
  // payload; reports counts and the captured bit sequence (bit j = j-th bit observed).
  task automatic run_frame(input int div, input int len, input bit cpol, input bit msb,
                           input logic [31:0] data, output int cs_low, output int caps,
                           output int shifts, output logic [31:0] rx);
    int  h, n, l, j;
    bit  ok;
    logic [8:0] act;
    logic       exp_bit;
    h = ((div < 2) ? 2 : div) + 1;
    n = (len == 0 || len > WIDTH) ? WIDTH : len;
    l = (2 * n + 1) * h;
    cs_low = 0; caps = 0; shifts = 0; rx = '0; j = 0;
    wait_ready(ok);
    if (!ok) return;
    @(negedge clk);
    cfg_clk_div   = DIV_WIDTH'(div);
    cfg_len       = LEN_W'(len);
    cfg_cpol      = cpol;
    cfg_msb_first = msb;
    tx_data       = data;
    for (int k = 0; k <= l + 1; k++) begin
      @(negedge clk);
      start_valid = (k == 0);
      if (k == 1) begin
        cfg_clk_div   = DIV_WIDTH'($urandom);
        cfg_len       = LEN_W'($urandom);
        cfg_cpol      = ~cpol;
        cfg_msb_first = ~msb;
      end
      #1;
      act = {cs_n, sclk, busy, start_ready, rx_valid, sr_load, sr_shift, sr_capture,
             sr_left_right};
      check($sformatf("frame_cycle k=%0d div=%0d len=%0d", k, div, len), 32'(act),
            32'(model_out(k, n, h, cpol, msb, last_msb)));
      if (!cs_n) cs_low++;
      if (sr_shift) shifts++;
      if (sr_capture) begin
        exp_bit = msb ? data[WIDTH - 1 - (j % WIDTH)] : data[j % WIDTH];
        check($sformatf("mosi_bit %0d", j), 32'(mosi), 32'(exp_bit));
        if (j < 32) rx[j] = mosi;
        caps++;
        j++;
      end
    end
    last_msb = msb;
  endtask

  typedef struct {
    int          div;
    int          len;
    bit          cpol;
    bit          msb;
    logic [31:0] data;
    int          exp_cs_low;
    int          exp_pulses;
    logic [31:0] exp_rx;
  } frame_vec_t;

  frame_vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cs_low, caps, shifts, cnt, n, l;
    logic [31:0] rx, exp_rx;
    bit          ok, hit;

    vecs[0] = '{2, 8, 1'b0, 1'b1, 32'hA500_0000, 51, 8, 32'h0000_00A5};
    vecs[1] = '{0, 8, 1'b0, 1'b1, 32'h3C00_0000, 51, 8, 32'h0000_003C};
    vecs[2] = '{1, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 195, 32, 32'hF77D_B57B};
    vecs[3] = '{3, 4, 1'b1, 1'b0, 32'h0000_000A, 36, 4, 32'h0000_000A};
    vecs[4] = '{4, 40, 1'b1, 1'b0, 32'h1234_5678, 325, 32, 32'h1234_5678};

    reset = 1'b0; start_valid = 1'b0; abort = 1'b0;
    cfg_clk_div = 8'd2; cfg_len = LEN_W'(8); cfg_cpol = 1'b1; cfg_msb_first = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_values", 32'({cs_n, sclk, mosi, start_ready, busy, rx_valid, sr_load,
                               sr_shift, sr_capture, sr_left_right}), 32'b10_1000_0001);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].div, vecs[v].len, vecs[v].cpol, vecs[v].msb, vecs[v].data,
                cs_low, caps, shifts, rx);
      check($sformatf("vec%0d cs_low_cycles", v), 32'(cs_low), 32'(vecs[v].exp_cs_low));
      check($sformatf("vec%0d captures", v), 32'(caps), 32'(vecs[v].exp_pulses));
      check($sformatf("vec%0d shifts", v), 32'(shifts), 32'(vecs[v].exp_pulses));
      check($sformatf("vec%0d rx_bits", v), rx, vecs[v].exp_rx);
    end

    for (int r = 0; r < 6; r++) begin
      int          div, len;
      bit          cpol, msb;
      logic [31:0] data;
      div = $urandom_range(0, 5); len = $urandom_range(0, 40);
      cpol = 1'($urandom); msb = 1'($urandom); data = $urandom;
      n = (len == 0 || len > WIDTH) ? WIDTH : len;
      l = (2 * n + 1) * (((div < 2) ? 2 : div) + 1);
      run_frame(div, len, cpol, msb, data, cs_low, caps, shifts, rx);
      exp_rx = '0;
      for (int b = 0; b < n; b++) exp_rx[b] = msb ? data[WIDTH - 1 - b] : data[b];
      check($sformatf("rand%0d cs_low_cycles", r), 32'(cs_low), 32'(l));
      check($sformatf("rand%0d captures", r), 32'(caps), 32'(n));
      check($sformatf("rand%0d shifts", r), 32'(shifts), 32'(n));
      check($sformatf("rand%0d rx_bits", r), rx, exp_rx);
    end

    // Request held high through a frame: accepted only in the rx_valid cycle.
    wait_ready(ok);
    @(negedge clk);
    cfg_clk_div = 8'd2; cfg_len = LEN_W'(2); cfg_cpol = 1'b0; cfg_msb_first = 1'b1;
    @(negedge clk);
    start_valid = 1'b1;
    #1;
    check("b2b first_accept", 32'(sr_load), 32'd1);
    cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      #1;
      if (sr_load || start_ready) cnt++;
    end
    check("b2b no_accept_while_busy", 32'(cnt), 32'd0);
    @(negedge clk);
    #1;
    check("b2b accept_in_rx_valid_cycle", 32'({rx_valid, sr_load, cs_n}), 32'b111);
    @(negedge clk);
    start_valid = 1'b0;
    #1;
    check("b2b cs_n_high_one_cycle", 32'({cs_n, busy, sr_shift}), 32'b011);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("b2b abort_to_idle", 32'({cs_n, busy, start_ready}), 32'b101);

    // Abort after the third capture; the next request (with abort still high) is taken
    // in the very next cycle.
    wait_ready(ok);
    @(negedge clk);
    cfg_clk_div = 8'd2; cfg_len = LEN_W'(8); cfg_cpol = 1'b1; cfg_msb_first = 1'b0;
    @(negedge clk);
    start_valid = 1'b1;
    cnt = 0; hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start_valid = 1'b0;
      #1;
      if (sr_capture) cnt++;
      if (cnt == 3) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort third_capture_reached", 32'(hit), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort still_shifting", 32'({busy, cs_n}), 32'b10);
    @(negedge clk);
    start_valid = 1'b1;
    #1;
    check("abort idle_next_cycle", 32'({cs_n, sclk, busy, rx_valid, sr_shift, sr_capture,
                                        start_ready, sr_load}), 32'b1100_0011);
    @(negedge clk);
    start_valid = 1'b0;
    abort = 1'b0;
    #1;
    check("abort new_frame_started", 32'({cs_n, busy, sr_shift}), 32'b011);

    // Asynchronous reset while sclk is at its active level.
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (sclk == 1'b0) begin
        hit = 1'b1;
        break;
      end
    end
    check("reset mid_shift_reached", 32'(hit), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("reset async_values", 32'({cs_n, sclk, mosi, start_ready, busy, rx_valid, sr_load,
                                     sr_shift, sr_capture, sr_left_right}), 32'b10_1000_0001);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset released_not_ready_yet", 32'({start_ready, busy, cs_n}), 32'b001);
    @(negedge clk);
    #1;
    check("reset ready_one_cycle_later", 32'({start_ready, busy, cs_n, sclk}), 32'b1011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
